// File: rtl/sdram_access_scheduler_pkg.sv
// Shared encodings for the SDRAM access scheduler: command types, FSM states
// and the linear-address slice positions used by the controller and traversal logic.
package sdram_access_scheduler_pkg;

    localparam int ADDR_W = 24;
    localparam int FILL_W = ADDR_W + 1;

    // Row-fastest mapping: consecutive words walk rows, then columns, then banks
    localparam int BA_HI  = 23;
    localparam int BA_LO  = 22;
    localparam int COL_HI = 21;
    localparam int COL_LO = 13;
    localparam int ROW_HI = 12;
    localparam int ROW_LO = 0;

    typedef enum logic [1:0] {
        CMD_NOP     = 2'b00,
        CMD_WRITE   = 2'b01,
        CMD_READ    = 2'b10,
        CMD_REFRESH = 2'b11
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sdram_access_scheduler_if.sv
// Request/grant and SDRAM command bus of the access scheduler.
// master = the scheduler, slave = requesters plus SDRAM controller side.
interface sdram_access_scheduler_if;
    import sdram_access_scheduler_pkg::*;

    logic                          WR_REQ;
    logic                          RD_REQ;
    logic                          CMD_READY;
    logic                          CMD_DONE;
    logic                          CMD_VALID;
    cmd_t                          CMD_TYPE;
    logic [BA_HI-BA_LO:0]          BA_OUT;
    logic [COL_HI-COL_LO:0]        COL_OUT;
    logic [ROW_HI-ROW_LO:0]        ROW_OUT;
    logic                          WR_GNT;
    logic                          RD_GNT;
    logic [FILL_W-1:0]             FILL_LEVEL;
    logic                          FULL;
    logic                          EMPTY;

    modport master (
        input  WR_REQ, RD_REQ, CMD_READY, CMD_DONE,
        output CMD_VALID, CMD_TYPE, BA_OUT, COL_OUT, ROW_OUT,
               WR_GNT, RD_GNT, FILL_LEVEL, FULL, EMPTY
    );

    modport slave (
        output WR_REQ, RD_REQ, CMD_READY, CMD_DONE,
        input  CMD_VALID, CMD_TYPE, BA_OUT, COL_OUT, ROW_OUT,
               WR_GNT, RD_GNT, FILL_LEVEL, FULL, EMPTY
    );

endinterface

// File: rtl/sdram_access_scheduler_refresh_timer.sv
// Free-running refresh interval counter; raises ref_pending on each expiry
// and holds it until the scheduler reports the REFRESH command accepted.
module sdram_refresh_timer #(
    parameter int REF_INTERVAL = 780,
    parameter int REF_CNT_W    = 10
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clear,
    output logic ref_pending
);

    logic [REF_CNT_W-1:0] cnt_reg;
    logic                 pending_reg;
    logic                 expire;

    assign expire      = (cnt_reg == REF_CNT_W'(REF_INTERVAL - 1));
    assign ref_pending = pending_reg;

    // A fresh expiry wins over a coincident clear so no interval is lost
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cnt_reg     <= '0;
            pending_reg <= 1'b0;
        end else begin
            cnt_reg <= expire ? '0 : cnt_reg + 1'b1;
            if (expire)
                pending_reg <= 1'b1;
            else if (clear)
                pending_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/sdram_access_scheduler.sv
// Arbitrates the single SDRAM command port between logging writes, downlink reads
// and auto-refresh; owns the circular write/read pointers and the fill level.
module sdram_access_scheduler
    import sdram_access_scheduler_pkg::*;
#(
    parameter int REF_INTERVAL = 780,
    parameter int REF_CNT_W    = 10
) (
    input  logic                       CLK,
    input  logic                       RESET,
    sdram_access_scheduler_if.master   bus
);

    state_t              state_reg, state_next;
    cmd_t                cmd_type_reg, sel_cmd;
    logic [ADDR_W-1:0]   addr_reg;
    logic [ADDR_W-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [ADDR_W-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [FILL_W-1:0]   fill_reg, fill_next;
    logic                last_wr_reg;
    logic                wr_gnt_reg, rd_gnt_reg;
    logic                ref_pending, ref_clear;
    logic                full, empty, wr_ok, rd_ok, done_ev, cmd_valid;

    sdram_refresh_timer #(
        .REF_INTERVAL (REF_INTERVAL),
        .REF_CNT_W    (REF_CNT_W)
    ) u_refresh_timer (
        .CLK         (CLK),
        .RESET       (RESET),
        .clear       (ref_clear),
        .ref_pending (ref_pending)
    );

    assign full      = (fill_reg == FILL_W'(1) << ADDR_W);
    assign empty     = (fill_reg == '0);
    assign wr_ok     = bus.WR_REQ && !full;
    assign rd_ok     = bus.RD_REQ && !empty;
    assign done_ev   = (state_reg == ST_WAIT_DONE) && bus.CMD_DONE;
    assign ref_clear = (state_reg == ST_ISSUE) && bus.CMD_READY && (cmd_type_reg == CMD_REFRESH);

    // Refresh first, then round-robin between the two data paths
    always_comb begin
        sel_cmd = CMD_NOP;
        if (ref_pending)
            sel_cmd = CMD_REFRESH;
        else if (wr_ok && rd_ok)
            sel_cmd = last_wr_reg ? CMD_READ : CMD_WRITE;
        else if (wr_ok)
            sel_cmd = CMD_WRITE;
        else if (rd_ok)
            sel_cmd = CMD_READ;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:      if (sel_cmd != CMD_NOP) state_next = ST_ISSUE;
            ST_ISSUE:     if (bus.CMD_READY)      state_next = ST_WAIT_DONE;
            ST_WAIT_DONE: if (bus.CMD_DONE)       state_next = ST_IDLE;
            default:                              state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_valid = (state_reg == ST_ISSUE);
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        fill_next   = fill_reg;
        if (done_ev) begin
            if (cmd_type_reg == CMD_WRITE) begin
                wr_ptr_next = wr_ptr_reg + 1'b1;
                fill_next   = fill_reg + 1'b1;
            end else if (cmd_type_reg == CMD_READ) begin
                rd_ptr_next = rd_ptr_reg + 1'b1;
                fill_next   = fill_reg - 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cmd_type_reg <= CMD_NOP;
            addr_reg     <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            fill_reg     <= '0;
            last_wr_reg  <= 1'b0;
            wr_gnt_reg   <= 1'b0;
            rd_gnt_reg   <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            fill_reg   <= fill_next;
            wr_gnt_reg <= done_ev && (cmd_type_reg == CMD_WRITE);
            rd_gnt_reg <= done_ev && (cmd_type_reg == CMD_READ);
            if ((state_reg == ST_IDLE) && (sel_cmd != CMD_NOP)) begin
                cmd_type_reg <= sel_cmd;
                addr_reg     <= (sel_cmd == CMD_WRITE) ? wr_ptr_reg :
                                (sel_cmd == CMD_READ)  ? rd_ptr_reg : '0;
                if (sel_cmd != CMD_REFRESH)
                    last_wr_reg <= (sel_cmd == CMD_WRITE);
            end
        end
    end

    assign bus.CMD_VALID  = cmd_valid;
    assign bus.CMD_TYPE   = cmd_type_reg;
    assign bus.BA_OUT     = addr_reg[BA_HI:BA_LO];
    assign bus.COL_OUT    = addr_reg[COL_HI:COL_LO];
    assign bus.ROW_OUT    = addr_reg[ROW_HI:ROW_LO];
    assign bus.WR_GNT     = wr_gnt_reg;
    assign bus.RD_GNT     = rd_gnt_reg;
    assign bus.FILL_LEVEL = fill_reg;
    assign bus.FULL       = full;
    assign bus.EMPTY      = empty;

endmodule

// File: tb/tb_sdram_access_scheduler.sv
// Directed bench for sdram_access_scheduler with a behavioural SDRAM controller
// that accepts commands and returns CMD_DONE one cycle after acceptance.
module tb_sdram_access_scheduler;
    import sdram_access_scheduler_pkg::*;

    logic CLK;
    logic RESET;
    sdram_access_scheduler_if bus();

    sdram_access_scheduler dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic ready_mode  = 1'b1;
    logic done_en     = 1'b1;
    logic inject_done = 1'b0;
    logic done_owed   = 1'b0;
    int   wr_gnt_cnt  = 0;
    int   rd_gnt_cnt  = 0;
    int   fill_jumps  = 0;
    int   prev_fill   = 0;
    logic fill_seen   = 1'b0;

    cmd_t        log_type[$];
    logic [1:0]  log_ba[$];
    logic [8:0]  log_col[$];
    logic [12:0] log_row[$];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Controller model and monitor: sample on negedge, drive just after posedge
    initial begin
        logic acc;
        int   d;
        bus.CMD_READY = 1'b0;
        bus.CMD_DONE  = 1'b0;
        forever begin
            @(negedge CLK);
            acc = RESET && bus.CMD_VALID && bus.CMD_READY;
            if (acc) begin
                log_type.push_back(bus.CMD_TYPE);
                log_ba.push_back(bus.BA_OUT);
                log_col.push_back(bus.COL_OUT);
                log_row.push_back(bus.ROW_OUT);
                $display("cmd: type=%0d ba=%0d col=%0d row=%0d fill=%0d", bus.CMD_TYPE,
                         bus.BA_OUT, bus.COL_OUT, bus.ROW_OUT, bus.FILL_LEVEL);
            end
            if (RESET) begin
                if (fill_seen) begin
                    d = int'(bus.FILL_LEVEL) - prev_fill;
                    if (d > 1 || d < -1) fill_jumps++;
                end
                prev_fill = int'(bus.FILL_LEVEL);
                fill_seen = 1'b1;
            end else begin
                fill_seen = 1'b0;
            end
            if (bus.WR_GNT) wr_gnt_cnt++;
            if (bus.RD_GNT) rd_gnt_cnt++;
            @(posedge CLK);
            #1;
            if (acc) done_owed = 1'b1;
            bus.CMD_READY = ready_mode;
            bus.CMD_DONE  = inject_done;
            if (done_owed && done_en) begin
                bus.CMD_DONE = 1'b1;
                done_owed    = 1'b0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    task automatic do_reset;
        RESET       = 1'b0;
        bus.WR_REQ  = 1'b0;
        bus.RD_REQ  = 1'b0;
        ready_mode  = 1'b1;
        done_en     = 1'b1;
        inject_done = 1'b0;
        step(2);
        done_owed = 1'b0;
        log_type.delete();
        log_ba.delete();
        log_col.delete();
        log_row.delete();
        wr_gnt_cnt = 0;
        rd_gnt_cnt = 0;
        fill_jumps = 0;
        RESET = 1'b1;
    endtask

    task automatic wait_log(input int n, input string tag);
        int c = 0;
        while (log_type.size() < n && c < 200) begin
            step(1);
            c++;
        end
        total++;
        if (log_type.size() < n) begin
            bad++;
            $display("FAIL %s: timeout, commands=%0d required=%0d", tag, log_type.size(), n);
        end
    endtask

    task automatic do_ops(input logic wr, input logic rd, input int n, input string tag);
        int base = log_type.size();
        bus.WR_REQ = wr;
        bus.RD_REQ = rd;
        wait_log(base + n, tag);
        bus.WR_REQ = 1'b0;
        bus.RD_REQ = 1'b0;
        step(4);
    endtask

    task automatic test_reset;
        RESET = 1'b0;
        bus.WR_REQ = 1'b0;
        bus.RD_REQ = 1'b0;
        step(2);
        total++;
        if (bus.CMD_VALID !== 1'b0 || bus.CMD_TYPE !== CMD_NOP) begin
            bad++;
            $display("FAIL reset_cmd: valid=%b type=%0d required 0/0", bus.CMD_VALID, bus.CMD_TYPE);
        end
        total++;
        if ({bus.BA_OUT, bus.COL_OUT, bus.ROW_OUT} !== 24'd0 || bus.WR_GNT !== 1'b0 || bus.RD_GNT !== 1'b0) begin
            bad++;
            $display("FAIL reset_addr_gnt: addr=%h wr_gnt=%b rd_gnt=%b required 0",
                     {bus.BA_OUT, bus.COL_OUT, bus.ROW_OUT}, bus.WR_GNT, bus.RD_GNT);
        end
        total++;
        if (bus.FILL_LEVEL !== 25'd0 || bus.FULL !== 1'b0 || bus.EMPTY !== 1'b1) begin
            bad++;
            $display("FAIL reset_fill: fill=%0d full=%b empty=%b required 0/0/1",
                     bus.FILL_LEVEL, bus.FULL, bus.EMPTY);
        end
        $display("test_reset done");
    endtask

    task automatic test_write5;
        do_reset();
        do_ops(1'b1, 1'b0, 5, "write5_wait");
        total++;
        if (log_type.size() != 5) begin
            bad++;
            $display("FAIL write5_count: commands=%0d required=5", log_type.size());
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (log_type[i] !== CMD_WRITE || {log_ba[i], log_col[i], log_row[i]} !== 24'(i)) begin
                bad++;
                $display("FAIL write5_cmd%0d: type=%0d addr=%h required 1/%h", i, log_type[i],
                         {log_ba[i], log_col[i], log_row[i]}, 24'(i));
            end
        end
        total++;
        if (wr_gnt_cnt != 5 || bus.FILL_LEVEL !== 25'd5 || bus.EMPTY !== 1'b0) begin
            bad++;
            $display("FAIL write5_fill: gnts=%0d fill=%0d empty=%b required 5/5/0",
                     wr_gnt_cnt, bus.FILL_LEVEL, bus.EMPTY);
        end
    endtask

    task automatic test_read_drain;
        do_reset();
        do_ops(1'b1, 1'b0, 2, "drain_fill_wait");
        total++;
        if (bus.FILL_LEVEL !== 25'd2) begin
            bad++;
            $display("FAIL drain_pre_fill: fill=%0d required 2", bus.FILL_LEVEL);
        end
        bus.RD_REQ = 1'b1;
        step(30);
        bus.RD_REQ = 1'b0;
        step(2);
        total++;
        if (log_type.size() != 4) begin
            bad++;
            $display("FAIL drain_count: commands=%0d required=4", log_type.size());
        end
        for (int i = 0; i < 2; i++) begin
            total++;
            if (log_type[i+2] !== CMD_READ || {log_ba[i+2], log_col[i+2], log_row[i+2]} !== 24'(i)) begin
                bad++;
                $display("FAIL drain_read%0d: type=%0d addr=%h required 2/%h", i, log_type[i+2],
                         {log_ba[i+2], log_col[i+2], log_row[i+2]}, 24'(i));
            end
        end
        total++;
        if (rd_gnt_cnt != 2 || bus.FILL_LEVEL !== 25'd0 || bus.EMPTY !== 1'b1) begin
            bad++;
            $display("FAIL drain_empty: gnts=%0d fill=%0d empty=%b required 2/0/1",
                     rd_gnt_cnt, bus.FILL_LEVEL, bus.EMPTY);
        end
    endtask

    task automatic test_round_robin;
        cmd_t        exp_t[4];
        logic [12:0] exp_r[4];
        exp_t = '{CMD_WRITE, CMD_READ, CMD_WRITE, CMD_READ};
        exp_r = '{13'd2, 13'd1, 13'd3, 13'd2};
        do_reset();
        do_ops(1'b1, 1'b0, 2, "rr_w_wait");
        do_ops(1'b0, 1'b1, 1, "rr_r_wait");
        fill_jumps = 0;
        do_ops(1'b1, 1'b1, 4, "rr_both_wait");
        total++;
        if (log_type.size() != 7) begin
            bad++;
            $display("FAIL rr_count: commands=%0d required=7", log_type.size());
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (log_type[i+3] !== exp_t[i] || log_row[i+3] !== exp_r[i]) begin
                bad++;
                $display("FAIL rr_op%0d: type=%0d row=%0d required %0d/%0d", i,
                         log_type[i+3], log_row[i+3], exp_t[i], exp_r[i]);
            end
        end
        total++;
        if (fill_jumps != 0 || bus.FILL_LEVEL !== 25'd1) begin
            bad++;
            $display("FAIL rr_fill: jumps=%0d fill=%0d required 0/1", fill_jumps, bus.FILL_LEVEL);
        end
    endtask

    task automatic test_refresh_idle;
        int cnt = 0;
        do_reset();
        while (!bus.CMD_VALID && cnt < 900) begin
            step(1);
            cnt++;
        end
        total++;
        if (cnt != 781 || bus.CMD_TYPE !== CMD_REFRESH) begin
            bad++;
            $display("FAIL refresh_idle_time: cycles=%0d type=%0d required 781/3", cnt, bus.CMD_TYPE);
        end
        total++;
        if ({bus.BA_OUT, bus.COL_OUT, bus.ROW_OUT} !== 24'd0) begin
            bad++;
            $display("FAIL refresh_idle_addr: addr=%h required 0", {bus.BA_OUT, bus.COL_OUT, bus.ROW_OUT});
        end
        step(8);
        total++;
        if (log_type.size() != 1 || bus.CMD_VALID !== 1'b0 || wr_gnt_cnt + rd_gnt_cnt != 0) begin
            bad++;
            $display("FAIL refresh_idle_once: commands=%0d valid=%b gnts=%0d required 1/0/0",
                     log_type.size(), bus.CMD_VALID, wr_gnt_cnt + rd_gnt_cnt);
        end
    endtask

    task automatic test_refresh_during_write;
        do_reset();
        done_en = 1'b0;
        step(770);
        bus.WR_REQ = 1'b1;
        step(15);
        done_en = 1'b1;
        wait_log(3, "ref_wr_wait");
        bus.WR_REQ = 1'b0;
        step(4);
        total++;
        if (log_type[0] !== CMD_WRITE || log_type[1] !== CMD_REFRESH || log_type[2] !== CMD_WRITE) begin
            bad++;
            $display("FAIL ref_wr_order: types=%0d,%0d,%0d required 1,3,1",
                     log_type[0], log_type[1], log_type[2]);
        end
        total++;
        if (log_row[0] !== 13'd0 || log_row[2] !== 13'd1 || wr_gnt_cnt != 2) begin
            bad++;
            $display("FAIL ref_wr_rows: rows=%0d,%0d gnts=%0d required 0,1/2",
                     log_row[0], log_row[2], wr_gnt_cnt);
        end
    endtask

    task automatic test_wrap_full;
        do_reset();
        force dut.wr_ptr_reg = 24'hFFFFFF;
        force dut.fill_reg   = 25'h0FFFFFF;
        step(2);
        release dut.wr_ptr_reg;
        release dut.fill_reg;
        step(1);
        do_ops(1'b1, 1'b0, 1, "wrap_w_wait");
        total++;
        if (log_ba[0] !== 2'd3 || log_col[0] !== 9'd511 || log_row[0] !== 13'd8191) begin
            bad++;
            $display("FAIL wrap_top_addr: ba=%0d col=%0d row=%0d required 3/511/8191",
                     log_ba[0], log_col[0], log_row[0]);
        end
        total++;
        if (bus.FILL_LEVEL !== 25'h1000000 || bus.FULL !== 1'b1 || bus.EMPTY !== 1'b0) begin
            bad++;
            $display("FAIL wrap_full: fill=%h full=%b empty=%b required 1000000/1/0",
                     bus.FILL_LEVEL, bus.FULL, bus.EMPTY);
        end
        bus.WR_REQ = 1'b1;
        step(20);
        bus.WR_REQ = 1'b0;
        step(2);
        total++;
        if (log_type.size() != 1) begin
            bad++;
            $display("FAIL wrap_full_holdoff: commands=%0d required=1", log_type.size());
        end
        do_ops(1'b0, 1'b1, 1, "wrap_r_wait");
        total++;
        if (log_type[1] !== CMD_READ || bus.FULL !== 1'b0) begin
            bad++;
            $display("FAIL wrap_read: type=%0d full=%b required 2/0", log_type[1], bus.FULL);
        end
        do_ops(1'b1, 1'b0, 1, "wrap_w2_wait");
        total++;
        if (log_type[2] !== CMD_WRITE || {log_ba[2], log_col[2], log_row[2]} !== 24'd0) begin
            bad++;
            $display("FAIL wrap_next_addr: type=%0d addr=%h required 1/0", log_type[2],
                     {log_ba[2], log_col[2], log_row[2]});
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        do_ops(1'b1, 1'b0, 1, "mid_w_wait");
        ready_mode = 1'b0;
        step(1);
        bus.RD_REQ = 1'b1;
        step(3);
        total++;
        if (bus.CMD_VALID !== 1'b1 || bus.CMD_TYPE !== CMD_READ) begin
            bad++;
            $display("FAIL mid_pending: valid=%b type=%0d required 1/2", bus.CMD_VALID, bus.CMD_TYPE);
        end
        #1;
        RESET = 1'b0;
        #1;
        total++;
        if (bus.CMD_VALID !== 1'b0 || bus.FILL_LEVEL !== 25'd0 || bus.EMPTY !== 1'b1) begin
            bad++;
            $display("FAIL mid_async: valid=%b fill=%0d empty=%b required 0/0/1",
                     bus.CMD_VALID, bus.FILL_LEVEL, bus.EMPTY);
        end
        bus.RD_REQ = 1'b0;
        step(1);
        RESET       = 1'b1;
        ready_mode  = 1'b1;
        inject_done = 1'b1;
        step(1);
        inject_done = 1'b0;
        step(4);
        total++;
        if (rd_gnt_cnt != 0 || bus.FILL_LEVEL !== 25'd0 || bus.CMD_VALID !== 1'b0 || log_type.size() != 1) begin
            bad++;
            $display("FAIL mid_stale_done: rd_gnts=%0d fill=%0d valid=%b commands=%0d required 0/0/0/1",
                     rd_gnt_cnt, bus.FILL_LEVEL, bus.CMD_VALID, log_type.size());
        end
    endtask

    initial begin
        RESET      = 1'b1;
        bus.WR_REQ = 1'b0;
        bus.RD_REQ = 1'b0;
        #3;
        test_reset();
        test_write5();
        test_read_drain();
        test_round_robin();
        test_refresh_idle();
        test_refresh_during_write();
        test_wrap_full();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
